relu_layer_seq: RTL and testbench

Sequencer that applies the shared combinational ReLU unit (`din_relu`/`dout_relu`, 16-bit two's complement) to one layer's worth of neuron accumulator results. On `start` it streams `num_neurons` words from the accumulator buffer through the ReLU and writes the results into the activation buffer, honouring write back-pressure. It sits between the MAC layer engine and the next layer's input buffer in the MNIST inference pipeline. On the final layer it can also report the arg-max class.

---
 rtl/relu_layer_seq.sv | 177 +++++++++++++++++
 tb/tb_relu_layer_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/relu_layer_seq.sv
// rtl/relu_layer_seq.sv - streams one layer of accumulator words through the shared ReLU into the activation buffer
// Arg-max tracking of the written activations is built only when ARGMAX_EN is defined.
module relu_layer_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] num_neurons_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] relu_din_o,
  input  logic [DATA_W-1:0] relu_dout_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] max_idx_o,
  output logic [DATA_W-1:0] max_val_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] rc_q, rc_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              rv_q, rv_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              start_acc;
  logic              stall;
  logic              fire;
  logic              last_fire;
  logic              rd_en;
  logic              in_valid;
  logic [DATA_W-1:0] relu_din;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign stall     = wr_en_q && !wr_ready_i;
  assign fire      = wr_en_q && wr_ready_i;
  assign last_fire = fire && (wr_addr_q == n_q - ADDR_W'(1));
  assign in_valid  = skid_full_q || rv_q;

  // A full skid entry always drains in any non-stalled cycle, so a read issued
  // then cannot collide with it; stall alone is enough to hold off reads.
  assign rd_en = (state_q == S_RUN) && (rc_q < n_q) && !stall;

  always_comb begin
    relu_din = '0;
    if (skid_full_q) begin
      relu_din = skid_data_q;
    end else if (rv_q) begin
      relu_din = rd_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    rc_d        = rc_q;
    wc_d        = wc_q;
    rv_d        = rd_en;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d     = num_neurons_i;
          rc_d    = '0;
          wc_d    = '0;
          state_d = (num_neurons_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          rc_d = rc_q + ADDR_W'(1);
        end
        if (last_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!stall) begin
      wr_en_d = in_valid;
      if (in_valid) begin
        wr_data_d   = relu_dout_i;
        wr_addr_d   = wc_q;
        wc_d        = wc_q + ADDR_W'(1);
        skid_full_d = 1'b0;
      end
    end else if (rv_q) begin
      skid_full_d = 1'b1;
      skid_data_d = relu_dout_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      rc_q        <= '0;
      wc_q        <= '0;
      rv_q        <= 1'b0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      rc_q        <= rc_d;
      wc_q        <= wc_d;
      rv_q        <= rv_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef ARGMAX_EN
  logic [ADDR_W-1:0] max_idx_q;
  logic [DATA_W-1:0] max_val_q;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else if (start_acc) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else if (fire && ($signed(wr_data_q) > $signed(max_val_q))) begin
      max_idx_q <= wr_addr_q;
      max_val_q <= wr_data_q;
    end
  end

  assign max_idx_o = max_idx_q;
  assign max_val_o = max_val_q;
`else
  assign max_idx_o = '0;
  assign max_val_o = '0;
`endif

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign rd_en_o    = rd_en;
  assign rd_addr_o  = rc_q;
  assign relu_din_o = relu_din;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_relu_layer_seq.sv
// tb/tb_relu_layer_seq.sv - directed self-checking bench for relu_layer_seq
module tb_relu_layer_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  num_neurons;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] relu_din;
  logic [15:0] relu_dout;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [9:0]  max_idx;
  logic [15:0] max_val;

  relu_layer_seq #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_neurons_i(num_neurons),
    .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .relu_din_o(relu_din), .relu_dout_i(relu_dout),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .max_idx_o(max_idx), .max_val_o(max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:15];
  assign relu_dout = relu_din[15] ? 16'd0 : relu_din;

  initial rd_data = 16'd0;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int nw, nrd, nwe, ndone, done_cyc, hold1;
  int wa [0:15];
  int wd [0:15];
  int wcy [0:15];

  always @(negedge clk) begin
    if (wr_en && wr_ready && nw < 16) begin
      wa[nw] = int'(wr_addr);
      wd[nw] = int'(wr_data);
      wcy[nw] = cyc - t0;
      nw++;
    end
    if (wr_en) nwe++;
    if (wr_en && wr_addr == 10'd1) hold1++;
    if (rd_en) nrd++;
    if (done) begin
      ndone++;
      done_cyc = cyc - t0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input int n, input int lo, input int hi, input int extra_k,
                          input int rst_k, input int ncyc);
    nw = 0; nrd = 0; nwe = 0; ndone = 0; done_cyc = -1; hold1 = 0;
    @(posedge clk); #1;
    t0 = cyc;
    num_neurons = 10'(n);
    start = 1'b1;
    wr_ready = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = (k == extra_k);
      if (k == extra_k) num_neurons = 10'd7;
      wr_ready = !(k >= lo && k <= hi);
      rst = (k == rst_k);
      if (k == rst_k) begin
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_rd_en", int'(rd_en), 0);
        chk("rst_mid_wr_en", int'(wr_en), 0);
        chk("rst_mid_wr_data", int'(wr_data), 0);
        chk("rst_mid_relu_din", int'(relu_din), 0);
        chk("rst_mid_done", int'(done), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_neurons = '0; wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_max_val", int'(max_val), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic pass
    mem[0] = 16'd1000; mem[1] = 16'hFBA9; mem[2] = 16'd0; mem[3] = 16'd32767;
    run_pass(4, -1, -1, -1, -1, 12);
    chk("basic_nw", nw, 4);
    chk("basic_nrd", nrd, 4);
    chk("basic_done_cyc", done_cyc, 7);
    chk("basic_ndone", ndone, 1);
    chk("basic_d0", wd[0], 1000);
    chk("basic_d1", wd[1], 0);
    chk("basic_d2", wd[2], 0);
    chk("basic_d3", wd[3], 32767);
    chk("basic_a3", wa[3], 3);
    chk("basic_c0", wcy[0], 3);
    chk("basic_c3", wcy[3], 6);
    chk("basic_busy_end", int'(busy), 0);
`ifdef ARGMAX_EN
    chk("basic_max_idx", int'(max_idx), 3);
    chk("basic_max_val", int'(max_val), 32767);
`else
    chk("basic_max_idx", int'(max_idx), 0);
    chk("basic_max_val", int'(max_val), 0);
`endif

    // Back-pressure at cycles 4-5
    run_pass(4, 4, 5, -1, -1, 14);
    chk("bp_nw", nw, 4);
    chk("bp_hold1", hold1, 3);
    chk("bp_d0", wd[0], 1000);
    chk("bp_d1", wd[1], 0);
    chk("bp_a2", wa[2], 2);
    chk("bp_d3", wd[3], 32767);
    chk("bp_a3", wa[3], 3);
    chk("bp_c1", wcy[1], 6);
    chk("bp_c3", wcy[3], 8);
    chk("bp_done_cyc", done_cyc, 9);

    // Edge values and ties
    mem[0] = 16'h8000; mem[1] = 16'd500; mem[2] = 16'd500;
    run_pass(3, -1, -1, -1, -1, 10);
    chk("edge_nw", nw, 3);
    chk("edge_d0", wd[0], 0);
    chk("edge_d1", wd[1], 500);
    chk("edge_d2", wd[2], 500);
    chk("edge_done_cyc", done_cyc, 6);
`ifdef ARGMAX_EN
    chk("edge_max_idx", int'(max_idx), 1);
    chk("edge_max_val", int'(max_val), 500);
`else
    chk("edge_max_idx", int'(max_idx), 0);
`endif

    // Empty pass
    run_pass(0, -1, -1, -1, -1, 6);
    chk("empty_done_cyc", done_cyc, 1);
    chk("empty_ndone", ndone, 1);
    chk("empty_nrd", nrd, 0);
    chk("empty_nwe", nwe, 0);

    // Start while busy (num_neurons also changed to 7 mid-pass)
    mem[0] = 16'd1000; mem[1] = 16'hFBA9; mem[2] = 16'd0; mem[3] = 16'd32767;
    run_pass(4, -1, -1, 2, -1, 14);
    chk("sb_nw", nw, 4);
    chk("sb_ndone", ndone, 1);
    chk("sb_done_cyc", done_cyc, 7);
    chk("sb_nrd", nrd, 4);

    // Reset mid-pass at cycle 4
    run_pass(4, -1, -1, -1, 4, 10);
    chk("rst_nw", nw, 1);
    chk("rst_ndone", ndone, 0);

    mem[0] = 16'd5; mem[1] = 16'hFFFD;
    run_pass(2, -1, -1, -1, -1, 8);
    chk("after_rst_done_cyc", done_cyc, 5);
    chk("after_rst_nw", nw, 2);
    chk("after_rst_d0", wd[0], 5);
    chk("after_rst_d1", wd[1], 0);
    chk("after_rst_a1", wa[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
